// File: rtl/funct_generator_div.sv
// funct_generator_div: multi-cycle restoring signed divider (2W-bit dividend / W-bit divisor).
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o and a short-circuit divide-by-zero path.
module funct_generator_div #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enh,
    input  logic signed [2*DATA_WIDTH-1:0] dividend_i,
    input  logic signed [DATA_WIDTH-1:0]   divisor_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic signed [2*DATA_WIDTH-1:0] quotient_o,
    output logic signed [DATA_WIDTH-1:0]   remainder_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                           div_zero_o
`endif
);
    localparam int W  = DATA_WIDTH;
    localparam int QW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    // Magnitudes are formed one bit wider than the operand so the most negative value survives.
    function automatic logic [QW-1:0] mag_q(input logic signed [QW-1:0] v);
        logic signed [QW:0] ext;
        ext = {v[QW-1], v};
        return QW'(ext[QW] ? -ext : ext);
    endfunction

    function automatic logic [W-1:0] mag_d(input logic signed [W-1:0] v);
        logic signed [W:0] ext;
        ext = {v[W-1], v};
        return W'(ext[W] ? -ext : ext);
    endfunction

    function automatic logic signed [QW-1:0] sign_q(input logic [QW-1:0] mag, input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic signed [W-1:0] sign_r(input logic [W-1:0] mag, input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic [QW-1:0] q_sh;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs_mag;
    logic          q_neg;
    logic          r_neg;
    logic          dz;
`ifndef DIV_ZERO_FLAG_EN
    logic [W-1:0]  dvd_lo;
`endif

    logic [W:0] sh;
    logic       ge;

    assign sh = {rem, q_sh[QW-1]};
    assign ge = (sh >= {1'b0, dvs_mag});

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o  <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (enh) begin
                        q_sh    <= mag_q(dividend_i);
                        rem     <= '0;
                        dvs_mag <= mag_d(divisor_i);
                        q_neg   <= dividend_i[QW-1] ^ divisor_i[W-1];
                        r_neg   <= dividend_i[QW-1];
                        dz      <= (divisor_i == '0);
`ifndef DIV_ZERO_FLAG_EN
                        dvd_lo  <= dividend_i[W-1:0];
`endif
                        cnt     <= CW'(QW);
                        busy_o  <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
`ifdef DIV_ZERO_FLAG_EN
                    if (dz) state <= SIGN;
                    else
`endif
                    if (cnt == '0) begin
                        state <= SIGN;
                    end else begin
                        // Restoring step: keep the trial difference only when it did not borrow.
                        rem  <= W'(ge ? sh - {1'b0, dvs_mag} : sh);
                        q_sh <= {q_sh[QW-2:0], ge};
                        cnt  <= cnt - CW'(1);
                    end
                end
                SIGN: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_o <= dz;
                    if (dz) begin
                        quotient_o  <= '0;
                        remainder_o <= '0;
                    end else begin
                        quotient_o  <= sign_q(q_sh, q_neg);
                        remainder_o <= sign_r(rem, r_neg);
                    end
`else
                    if (dz) begin
                        quotient_o  <= '1;
                        remainder_o <= dvd_lo;
                    end else begin
                        quotient_o  <= sign_q(q_sh, q_neg);
                        remainder_o <= sign_r(rem, r_neg);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_funct_generator_div.sv
// Bench for funct_generator_div (W=16): directed and random divisions against an arithmetic model.
// Works with or without DIV_ZERO_FLAG_EN defined.
module tb_funct_generator_div;
    localparam int W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enh;
    logic signed [2*W-1:0] dividend_i;
    logic signed [W-1:0]   divisor_i;
    logic                  busy_o;
    logic                  done_o;
    logic signed [2*W-1:0] quotient_o;
    logic signed [W-1:0]   remainder_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_zero_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    funct_generator_div #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enh        (enh),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o (div_zero_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit signed / and % truncated to the output widths.
    function automatic void model(input logic signed [2*W-1:0] dvd, input logic signed [W-1:0] dvs,
                                  output logic signed [2*W-1:0] q, output logic signed [W-1:0] r,
                                  output logic dz);
        longint a, b;
        a = dvd;
        b = dvs;
        if (b == 0) begin
`ifdef DIV_ZERO_FLAG_EN
            q = '0; r = '0; dz = 1'b1;
`else
            q = '1; r = dvd[W-1:0]; dz = 1'b0;
`endif
        end else begin
            q  = (2*W)'(a / b);
            r  = W'(a % b);
            dz = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one division from IDLE, scramble inputs during the run, check latency and result.
    task automatic do_op(input string tag, input logic signed [2*W-1:0] dvd, input logic signed [W-1:0] dvs);
        logic signed [2*W-1:0] eq, q_prev;
        logic signed [W-1:0]   er, r_prev;
        logic                  edz;
        int                    lat, exp_lat;
        bit                    busy_ok, stable;
        model(dvd, dvs, eq, er, edz);
        exp_lat = 2*W + 2;
`ifdef DIV_ZERO_FLAG_EN
        if (dvs == 0) exp_lat = 2;
`endif
        q_prev = quotient_o;
        r_prev = remainder_o;
        dividend_i = dvd;
        divisor_i  = dvs;
        enh = 1'b1;
        step();
        enh = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        stable = 1'b1;
        while (done_o !== 1'b1 && lat < 200) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (quotient_o !== q_prev || remainder_o !== r_prev) stable = 1'b0;
            dividend_i = $urandom;
            divisor_i  = W'($urandom);
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy during op"}, {63'b0, busy_ok}, 64'd1);
        check({tag, " outputs held"}, {63'b0, stable}, 64'd1);
        check({tag, " quotient"}, quotient_o, eq);
        check({tag, " remainder"}, remainder_o, er);
        check({tag, " busy at done"}, {63'b0, busy_o}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " div_zero"}, {63'b0, div_zero_o}, {63'b0, edz});
`endif
        step();
        check({tag, " done pulse"}, {63'b0, done_o}, 64'd0);
        check({tag, " quotient hold"}, quotient_o, eq);
    endtask

    initial begin
        int ndone, done_at, n;
        logic signed [2*W-1:0] q_at;
        logic signed [W-1:0]   r_at;
        logic                  busy_after;

        rst = 1'b1;
        enh = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        step();
        step();
        check("reset quotient", quotient_o, 64'd0);
        check("reset remainder", remainder_o, 64'd0);
        check("reset busy", {63'b0, busy_o}, 64'd0);
        check("reset done", {63'b0, done_o}, 64'd0);
        rst = 1'b0;
        step();

        do_op("1000/7", 1000, 7);
        do_op("-1000/7", -1000, 7);
        do_op("1000/-7", 1000, -7);
        do_op("-1000/-7", -1000, -7);
        do_op("-15/5", -15, 5);
        do_op("min/-1", 32'sh8000_0000, -1);
        do_op("min/min16", 32'sh8000_0000, 16'sh8000);
        do_op("max/min16", 32'sh7FFF_FFFF, 16'sh8000);
        do_op("-1/max16", -1, 16'sh7FFF);
        do_op("55/0", 55, 0);
        do_op("-55/0", -55, 0);

        // enh held high: one result at 2W+2, then re-accept in the done cycle.
        dividend_i = 100;
        divisor_i  = 3;
        enh = 1'b1;
        ndone = 0;
        done_at = -1;
        q_at = '0;
        r_at = '0;
        busy_after = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done_o === 1'b1) begin
                ndone++;
                done_at = k;
                q_at = quotient_o;
                r_at = remainder_o;
            end
            if (k == 2*W + 3) busy_after = busy_o;
        end
        enh = 1'b0;
        check("held enh done count", 64'(ndone), 64'd1);
        check("held enh done edge", 64'(done_at), 64'(2*W + 2));
        check("held enh quotient", q_at, 64'd33);
        check("held enh remainder", r_at, 64'd1);
        check("held enh re-accept busy", {63'b0, busy_after}, 64'd1);
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("held enh second done edge", 64'(n + 39), 64'(2*W + 3 + 2*W + 2));
        check("held enh second quotient", quotient_o, 64'd33);
        step();

        // Reset in the middle of a calculation aborts it and clears outputs.
        dividend_i = 1000;
        divisor_i  = 7;
        enh = 1'b1;
        step();
        enh = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid reset quotient", quotient_o, 64'd0);
        check("mid reset remainder", remainder_o, 64'd0);
        check("mid reset busy", {63'b0, busy_o}, 64'd0);
        check("mid reset done", {63'b0, done_o}, 64'd0);
        repeat (40) begin
            step();
            if (done_o === 1'b1 || busy_o === 1'b1) n = -1;
        end
        check("aborted op stays quiet", 64'(n < 0), 64'd0);
        do_op("after reset 100/3", 100, 3);

        for (int i = 0; i < 20; i++) begin
            logic signed [2*W-1:0] a;
            logic signed [W-1:0]   b;
            a = $urandom;
            b = W'($urandom);
            if (i % 3 == 0) a = $signed(32'($urandom_range(0, 200000))) - 100000;
            if (i % 4 == 1) b = $signed(W'($urandom_range(0, 40))) - 20;
            do_op("random", a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
